tx_encoder: RTL and testbench

TX_ENCODER -- requirements
Module: tx_encoder

---
 rtl/tx_encoder_pkg.sv | 77 +++++++
 rtl/tx_encoder_crc.sv | 39 +++
 rtl/tx_encoder.sv | 221 ++++++++++++++++++++++
 tb/tb_tx_encoder.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_encoder_pkg.sv
// Shared definitions for the backscatter reply encoder: FSM states, encoding
// selects, symbol kinds, CRC constants, pilot lengths and preamble patterns.
package tx_encoder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PILOT,
        ST_PREAMBLE,
        ST_DATA,
        ST_CRC,
        ST_EOS,
        ST_DONE
    } tx_state_e;

    typedef enum logic [1:0] {
        MSEL_FM0 = 2'b00,
        MSEL_M2  = 2'b01,
        MSEL_M4  = 2'b10,
        MSEL_M8  = 2'b11
    } msel_e;

    // SYM_V: FM0 violation (data-0 shape without boundary inversion);
    // SYM_P: Miller pilot bit (subcarrier only, baseband never moves).
    typedef enum logic [1:0] {
        SYM_0,
        SYM_1,
        SYM_V,
        SYM_P
    } sym_e;

    localparam logic [15:0] CRC_POLY   = 16'h1021;
    localparam logic [15:0] CRC_PRESET = 16'hFFFF;

    localparam logic [10:0] PILOT_FM0          = 11'd0;
    localparam logic [10:0] PILOT_FM0_TREXT    = 11'd12;
    localparam logic [10:0] PILOT_MILLER       = 11'd4;
    localparam logic [10:0] PILOT_MILLER_TREXT = 11'd16;

    // Bit i of each pattern is preamble symbol i (transmitted first = bit 0).
    localparam logic [2:0] PREAMBLE_LAST     = 3'd5;
    localparam logic [2:0] PREAMBLE_FM0_VIOL = 3'd4;
    localparam logic [5:0] PREAMBLE_FM0      = 6'b100101;
    localparam logic [5:0] PREAMBLE_MILLER   = 6'b111010;

    function automatic sym_e preamble_sym(input logic fm0, input logic [2:0] idx);
        sym_e s;
        logic v;
        v = fm0 ? PREAMBLE_FM0[idx] : PREAMBLE_MILLER[idx];
        s = v ? SYM_1 : SYM_0;
        if (fm0 && idx == PREAMBLE_FM0_VIOL) begin
            s = SYM_V;
        end
        return s;
    endfunction

    function automatic logic [3:0] bit_len_m1(input msel_e m);
        logic [3:0] r;
        case (m)
            MSEL_FM0: r = 4'd1;
            MSEL_M2:  r = 4'd3;
            MSEL_M4:  r = 4'd7;
            default:  r = 4'd15;
        endcase
        return r;
    endfunction

    function automatic logic [10:0] pilot_len(input msel_e m, input logic trext);
        logic [10:0] r;
        if (m == MSEL_FM0) begin
            r = trext ? PILOT_FM0_TREXT : PILOT_FM0;
        end else begin
            r = trext ? PILOT_MILLER_TREXT : PILOT_MILLER;
        end
        return r;
    endfunction

endpackage

// File: rtl/tx_encoder_crc.sv
// Bit-serial CRC-16/CCITT with synchronous preset and shift enable; shared
// with the receive-side checker.
module crc16_serial
    import tx_encoder_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        init,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (init) begin
            crc_d = CRC_PRESET;
        end else if (en) begin
            crc_d = {crc_q[14:0], 1'b0};
            if (crc_q[15] ^ din) begin
                crc_d = crc_d ^ CRC_POLY;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            crc_q <= CRC_PRESET;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/tx_encoder.sv
// Reply encoder: sequences pilot, preamble, payload, CRC and end-of-signalling
// bits and shapes them as FM0 or Miller-subcarrier symbols on mod_out.
module tx_encoder
    import tx_encoder_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [1:0] m_sel,
    input  logic       trext,
    input  logic       crc_en,
    input  logic       tx_bit_src,
    input  logic       tx_data_done,
    output logic       data_clk,
    output logic       mod_out,
    output logic       tx_busy,
    output logic       tx_done
);

    tx_state_e   state_q, state_d;
    msel_e       msel_q, msel_d;
    logic        trext_q, trext_d;
    logic        crc_en_q, crc_en_d;
    logic [3:0]  tick_q, tick_d;
    logic [10:0] cnt_q, cnt_d;
    sym_e        sym_q, sym_d;
    logic        prev1_q, prev1_d;
    logic        last_q, last_d;
    logic        phase_q, phase_d;
    logic        mod_out_q, mod_out_d;
    logic        data_clk_q, data_clk_d;
    logic        tx_busy_q, tx_busy_d;
    logic        tx_done_q, tx_done_d;

    logic        crc_init;
    logic        crc_shift;
    logic [15:0] crc_val;
    logic        start;
    logic        fm0_d;
    logic        xmit_d;
    logic        base;
    logic [3:0]  lm1_q, lm1_d, half_d;

    crc16_serial u_crc (
        .clk   (clk),
        .reset (reset),
        .init  (crc_init),
        .en    (crc_shift),
        .din   (tx_bit_src),
        .crc   (crc_val)
    );

    assign lm1_q = bit_len_m1(msel_q);

    always_comb begin
        state_d   = state_q;
        msel_d    = msel_q;
        trext_d   = trext_q;
        crc_en_d  = crc_en_q;
        tick_d    = tick_q;
        cnt_d     = cnt_q;
        sym_d     = sym_q;
        prev1_d   = prev1_q;
        last_d    = last_q;
        crc_init  = 1'b0;
        crc_shift = 1'b0;
        start     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (tx_start) begin
                    start    = 1'b1;
                    crc_init = 1'b1;
                    msel_d   = msel_e'(m_sel);
                    trext_d  = trext;
                    crc_en_d = crc_en;
                    tick_d   = '0;
                    cnt_d    = '0;
                    prev1_d  = 1'b1;
                    last_d   = 1'b0;
                    if (pilot_len(msel_e'(m_sel), trext) != '0) begin
                        state_d = ST_PILOT;
                        sym_d   = (msel_e'(m_sel) == MSEL_FM0) ? SYM_0 : SYM_P;
                    end else begin
                        state_d = ST_PREAMBLE;
                        sym_d   = preamble_sym(msel_e'(m_sel) == MSEL_FM0, 3'd0);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                if (tick_q != lm1_q) begin
                    tick_d = tick_q + 4'd1;
                end else begin
                    tick_d  = '0;
                    cnt_d   = cnt_q + 11'd1;
                    prev1_d = (sym_q != SYM_0);
                    case (state_q)
                        ST_PILOT: begin
                            if (cnt_q == pilot_len(msel_q, trext_q) - 11'd1) begin
                                state_d = ST_PREAMBLE;
                                cnt_d   = '0;
                                sym_d   = preamble_sym(msel_q == MSEL_FM0, 3'd0);
                            end
                        end
                        ST_PREAMBLE: begin
                            if (cnt_q[2:0] == PREAMBLE_LAST) begin
                                state_d   = ST_DATA;
                                cnt_d     = '0;
                                sym_d     = tx_bit_src ? SYM_1 : SYM_0;
                                last_d    = tx_data_done;
                                crc_shift = 1'b1;
                            end else begin
                                sym_d = preamble_sym(msel_q == MSEL_FM0, cnt_q[2:0] + 3'd1);
                            end
                        end
                        ST_DATA: begin
                            if (!last_q) begin
                                sym_d     = tx_bit_src ? SYM_1 : SYM_0;
                                last_d    = tx_data_done;
                                crc_shift = 1'b1;
                            end else if (crc_en_q) begin
                                state_d = ST_CRC;
                                cnt_d   = '0;
                                sym_d   = crc_val[15] ? SYM_0 : SYM_1;
                            end else begin
                                state_d = ST_EOS;
                                sym_d   = SYM_1;
                            end
                        end
                        ST_CRC: begin
                            if (cnt_q[3:0] == 4'd15) begin
                                state_d = ST_EOS;
                                sym_d   = SYM_1;
                            end else begin
                                sym_d = crc_val[4'd14 - cnt_q[3:0]] ? SYM_0 : SYM_1;
                            end
                        end
                        default: begin
                            state_d = ST_DONE;
                        end
                    endcase
                end
            end
        endcase

        // Outputs are computed from the next-cycle slot so the registered
        // mod_out/data_clk line up with the tick counter they belong to.
        fm0_d  = (msel_d == MSEL_FM0);
        lm1_d  = bit_len_m1(msel_d);
        half_d = (lm1_d >> 1) + 4'd1;
        xmit_d = (state_d inside {ST_PILOT, ST_PREAMBLE, ST_DATA, ST_CRC, ST_EOS});
        base   = start ? 1'b0 : phase_q;

        phase_d = base;
        if (xmit_d) begin
            if (tick_d == '0) begin
                if (fm0_d) begin
                    phase_d = (sym_d == SYM_V) ? base : ~base;
                end else if (sym_d == SYM_0 && !prev1_d) begin
                    phase_d = ~base;
                end
            end else if (tick_d == half_d) begin
                if (fm0_d) begin
                    phase_d = (sym_d inside {SYM_0, SYM_V}) ? ~base : base;
                end else if (sym_d == SYM_1) begin
                    phase_d = ~base;
                end
            end
        end

        mod_out_d  = xmit_d & (fm0_d ? phase_d : (phase_d ^ tick_d[0]));
        data_clk_d = (tick_d == lm1_d) &&
                     ((state_d == ST_PREAMBLE && cnt_d[2:0] == PREAMBLE_LAST) ||
                      (state_d == ST_DATA && !last_d));
        tx_busy_d  = (state_d != ST_IDLE);
        tx_done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            msel_q     <= MSEL_FM0;
            trext_q    <= 1'b0;
            crc_en_q   <= 1'b0;
            tick_q     <= '0;
            cnt_q      <= '0;
            sym_q      <= SYM_0;
            prev1_q    <= 1'b1;
            last_q     <= 1'b0;
            phase_q    <= 1'b0;
            mod_out_q  <= 1'b0;
            data_clk_q <= 1'b0;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            msel_q     <= msel_d;
            trext_q    <= trext_d;
            crc_en_q   <= crc_en_d;
            tick_q     <= tick_d;
            cnt_q      <= cnt_d;
            sym_q      <= sym_d;
            prev1_q    <= prev1_d;
            last_q     <= last_d;
            phase_q    <= phase_d;
            mod_out_q  <= mod_out_d;
            data_clk_q <= data_clk_d;
            tx_busy_q  <= tx_busy_d;
            tx_done_q  <= tx_done_d;
        end
    end

    assign mod_out  = mod_out_q;
    assign data_clk = data_clk_q;
    assign tx_busy  = tx_busy_q;
    assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_tx_encoder.sv
// Self-checking bench for tx_encoder: random and directed replies compared
// tick-by-tick with a symbol-level waveform model, plus CRC/decoder checks.
module tb_tx_encoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_start;
    logic [1:0] m_sel;
    logic       trext;
    logic       crc_en;
    logic       tx_bit_src;
    logic       tx_data_done;
    logic       data_clk;
    logic       mod_out;
    logic       tx_busy;
    logic       tx_done;

    int n_tests = 0;
    int n_fail  = 0;

    bit payload[$];
    bit exp_w[$];
    bit got_w[$];
    bit dec[$];
    int dclk_cnt;
    int done_cnt;

    always #5 clk = ~clk;

    tx_encoder dut (
        .clk          (clk),
        .reset        (reset),
        .tx_start     (tx_start),
        .m_sel        (m_sel),
        .trext        (trext),
        .crc_en       (crc_en),
        .tx_bit_src   (tx_bit_src),
        .tx_data_done (tx_data_done),
        .data_clk     (data_clk),
        .mod_out      (mod_out),
        .tx_busy      (tx_busy),
        .tx_done      (tx_done)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] crc_of(input bit b[$]);
        logic [15:0] c = 16'hFFFF;
        foreach (b[i]) begin
            logic fb = c[15] ^ b[i];
            c = c << 1;
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    function automatic int pilot_n(input logic [1:0] ms, input logic te);
        if (ms == 2'b00) return te ? 12 : 0;
        return te ? 16 : 4;
    endfunction

    // Symbol codes: 0/1 data, 2 FM0 violation, 3 Miller pilot.
    task automatic build_expected(input logic [1:0] ms, input logic te, input logic ce);
        int syms[$];
        int pre[6];
        int m;
        logic [15:0] c;
        bit lvl;
        bit prev0;
        exp_w.delete();
        repeat (pilot_n(ms, te)) syms.push_back(ms == 2'b00 ? 0 : 3);
        if (ms == 2'b00) pre = '{1, 0, 1, 0, 2, 1};
        else             pre = '{0, 1, 0, 1, 1, 1};
        foreach (pre[i]) syms.push_back(pre[i]);
        foreach (payload[i]) syms.push_back(int'(payload[i]));
        if (ce) begin
            c = crc_of(payload);
            for (int i = 15; i >= 0; i--) syms.push_back(c[i] ? 0 : 1);
        end
        syms.push_back(1);
        if (ms == 2'b00) begin
            lvl = 1'b0;
            foreach (syms[k]) begin
                if (syms[k] != 2) lvl = !lvl;
                exp_w.push_back(lvl);
                if (syms[k] == 0 || syms[k] == 2) lvl = !lvl;
                exp_w.push_back(lvl);
            end
        end else begin
            m = 1 << ms;
            lvl = 1'b0;
            prev0 = 1'b0;
            foreach (syms[k]) begin
                if (syms[k] == 0 && prev0) lvl = !lvl;
                for (int t = 0; t < 2 * m; t++) begin
                    if (t == m && syms[k] == 1) lvl = !lvl;
                    exp_w.push_back(lvl ^ (t % 2 == 1));
                end
                prev0 = (syms[k] == 0);
            end
        end
    endtask

    task automatic decode(input bit fm0, input int len, input int first_slot, input int nbits);
        dec.delete();
        for (int k = 0; k < nbits; k++) begin
            int o = (first_slot + k) * len;
            if (fm0) dec.push_back(got_w[o] == got_w[o + 1]);
            else     dec.push_back(got_w[o] != got_w[o + len / 2]);
        end
    endtask

    task automatic run_reply(input logic [1:0] ms, input logic te, input logic ce,
                             input int restart_at, input int abort_at);
        int  idx = 0;
        bit  pend = 0;
        bit  ended = 0;
        bit  restarted = 0;
        int  mism = 0;
        int  busy_hi = 0;
        int  plen = payload.size();
        int  budget;
        build_expected(ms, te, ce);
        budget = exp_w.size() + 50;
        got_w.delete();
        dclk_cnt = 0;
        done_cnt = 0;
        @(negedge clk);
        m_sel = ms;
        trext = te;
        crc_en = ce;
        tx_bit_src = payload[0];
        tx_data_done = (plen == 1);
        tx_start = 1'b1;
        for (int cyc = 0; cyc < budget; cyc++) begin
            @(negedge clk);
            tx_start = 1'b0;
            if (pend) begin
                idx++;
                pend = 0;
            end
            if (data_clk) begin
                pend = 1;
                dclk_cnt++;
            end
            tx_bit_src   = (idx < plen) ? payload[idx] : 1'b0;
            tx_data_done = (idx >= plen - 1);
            if (tx_done) done_cnt++;
            if (!tx_busy) begin
                ended = 1;
                break;
            end
            if (!tx_done) got_w.push_back(mod_out);
            if (restart_at >= 0 && dclk_cnt == restart_at && !restarted) begin
                restarted = 1;
                tx_start = 1'b1;
                m_sel = 2'($urandom);
                trext = 1'($urandom);
                crc_en = 1'($urandom);
            end
            if (abort_at >= 0 && got_w.size() == abort_at) begin
                reset = 1'b0;
                #1;
                check_eq("abort_mod_out", mod_out, 1'b0);
                check_eq("abort_busy", tx_busy, 1'b0);
                check_eq("abort_data_clk", data_clk, 1'b0);
                repeat (6) begin
                    @(negedge clk);
                    if (tx_done) done_cnt++;
                    if (tx_busy) busy_hi++;
                end
                reset = 1'b1;
                repeat (6) begin
                    @(negedge clk);
                    if (tx_done) done_cnt++;
                    if (tx_busy) busy_hi++;
                end
                check_eq("abort_no_done", done_cnt, 0);
                check_eq("abort_stays_idle", busy_hi, 0);
                return;
            end
        end
        check_eq("reply_ended", ended, 1'b1);
        check_eq("wave_len", got_w.size(), exp_w.size());
        foreach (exp_w[i]) if (i >= got_w.size() || got_w[i] != exp_w[i]) mism++;
        check_eq("wave_mismatch_ticks", mism, 0);
        check_eq("data_clk_count", dclk_cnt, plen);
        check_eq("tx_done_count", done_cnt, 1);
        repeat (4) begin
            @(negedge clk);
            if (tx_busy || tx_done) busy_hi++;
        end
        check_eq("idle_after_done", busy_hi, 0);
    endtask

    task automatic rand_payload(input int n);
        payload.delete();
        repeat (n) payload.push_back(1'($urandom_range(0, 1)));
    endtask

    initial begin
        logic [15:0] w;
        int cnt;
        reset = 1'b0;
        tx_start = 1'b0;
        m_sel = 2'b00;
        trext = 1'b0;
        crc_en = 1'b0;
        tx_bit_src = 1'b0;
        tx_data_done = 1'b0;
        #1;
        check_eq("rst_mod_out", mod_out, 1'b0);
        check_eq("rst_data_clk", data_clk, 1'b0);
        check_eq("rst_busy", tx_busy, 1'b0);
        check_eq("rst_done", tx_done, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // FM0, no pilot, no CRC, payload 1,0,0,1
        payload = '{1, 0, 0, 1};
        run_reply(2'b00, 1'b0, 1'b0, -1, -1);
        for (int i = 0; i < 4; i++)
            check_eq("fm0_mid_inv", got_w[12 + 2 * i] != got_w[13 + 2 * i], payload[i] == 0);
        check_eq("fm0_eos_no_mid", got_w[20] != got_w[21], 1'b0);
        check_eq("fm0_eos_boundary", got_w[20] != got_w[19], 1'b1);

        // FM0 extended pilot and preamble violation
        rand_payload(8);
        run_reply(2'b00, 1'b1, 1'($urandom), -1, -1);
        cnt = 0;
        for (int k = 0; k < 12; k++) if (got_w[2 * k] != got_w[2 * k + 1]) cnt++;
        check_eq("fm0_pilot_zeros", cnt, 12);
        check_eq("fm0_pre_boundary", got_w[30] != got_w[29], 1'b1);
        check_eq("fm0_violation", got_w[32] == got_w[31], 1'b1);

        // M4, payload 0x1234 LSB first, CRC appended
        w = 16'h1234;
        payload.delete();
        for (int i = 0; i < 16; i++) payload.push_back(w[i]);
        run_reply(2'b10, 1'b0, 1'b1, -1, -1);
        decode(1'b0, 8, 10, 32);
        w = '0;
        for (int i = 0; i < 16; i++) w[i] = dec[i];
        check_eq("m4_decoded_data", w, 16'h1234);
        check_eq("m4_crc_residue", crc_of(dec), 16'h1D0F);

        // M8, maximum payload
        rand_payload(1024);
        run_reply(2'b11, 1'($urandom), 1'b1, -1, -1);

        // Restart request mid-DATA with config inputs changing
        rand_payload(40);
        run_reply(2'b01, 1'b1, 1'b1, 20, -1);

        // Reset asserted while in CRC
        rand_payload(20);
        run_reply(2'b01, 1'b0, 1'b1, -1, (4 + 6 + 20) * 4 + 5);

        // Single-bit payload with CRC
        rand_payload(1);
        run_reply(2'b10, 1'b0, 1'b1, -1, -1);
        decode(1'b0, 8, 10, 17);
        check_eq("one_bit_data", dec[0], payload[0]);
        check_eq("one_bit_residue", crc_of(dec), 16'h1D0F);

        // Random replies
        for (int r = 0; r < 6; r++) begin
            rand_payload($urandom_range(1, 40));
            run_reply(2'($urandom), 1'($urandom), 1'($urandom), -1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
